// File: rtl/vtree_feed_scheduler.sv
// Round-robin feed scheduler for the virtual merge sorter tree: hands one P-record
// block per cycle to an empty leaf, then closes each way with an all-ones terminator.
module vtree_feed_scheduler #(
  parameter int W_LOG = 3,
  parameter int P_LOG = 3,
  parameter int DATW  = 64,
  parameter int CNTW  = 32,
  parameter int HOLD  = 2,
  localparam int NW   = 1 << W_LOG,
  localparam int BW   = DATW << P_LOG
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               START,
  input  logic [CNTW-1:0]    LEN,
  input  logic [BW*NW-1:0]   SRC_DIN,
  input  logic [NW-1:0]      SRC_VLD,
  output logic [NW-1:0]      SRC_DEQ,
  input  logic [NW-1:0]      TREE_EMP,
  output logic [BW-1:0]      TREE_DIN,
  output logic               TREE_DINEN,
  output logic [W_LOG-1:0]   TREE_DIN_IDX,
  output logic               BUSY,
  output logic               DONE
);

  localparam int HW = 2;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

  state_t                     state_q, state_d;
  logic [NW-1:0][CNTW-1:0]    rem_q, rem_d;
  logic [NW-1:0]              term_q, term_d;
  logic [NW-1:0][HW-1:0]      hold_q, hold_d;
  logic [W_LOG-1:0]           ptr_q, ptr_d;
  logic [BW-1:0]              din_q, din_d;
  logic                       dinen_q, dinen_d;
  logic [W_LOG-1:0]           idx_q, idx_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;

  logic [NW-1:0]              req;
  logic                       gnt_vld;
  logic [W_LOG-1:0]           gnt;
  logic [W_LOG-1:0]           cand;
  logic                       hold_idle;
  logic                       gnt_data;

  always_comb begin
    req = '0;
    for (int unsigned i = 0; i < NW; i++) begin
      req[i] = (state_q == S_RUN) && TREE_EMP[i] && (hold_q[i] == '0) &&
               (((rem_q[i] != '0) && SRC_VLD[i]) || ((rem_q[i] == '0) && !term_q[i]));
    end
  end

  // Rotating priority search starting at ptr; the W_LOG-bit add wraps naturally.
  always_comb begin
    gnt_vld = 1'b0;
    gnt     = '0;
    cand    = '0;
    for (int unsigned k = 0; k < NW; k++) begin
      cand = ptr_q + W_LOG'(k);
      if (!gnt_vld && req[cand]) begin
        gnt_vld = 1'b1;
        gnt     = cand;
      end
    end
  end

  always_comb begin
    hold_idle = 1'b1;
    for (int unsigned i = 0; i < NW; i++) begin
      if (hold_q[i] != '0) hold_idle = 1'b0;
    end
  end

  assign gnt_data = gnt_vld && (rem_q[gnt] != '0);

  // Gated with RST so a dequeue is never issued for a block the reset will discard.
  assign SRC_DEQ = (gnt_data && !RST) ? (NW'(1) << gnt) : '0;

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    term_d  = term_q;
    ptr_d   = ptr_q;
    din_d   = din_q;
    dinen_d = 1'b0;
    idx_d   = idx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    for (int unsigned i = 0; i < NW; i++) begin
      hold_d[i] = (hold_q[i] != '0) ? hold_q[i] - HW'(1) : '0;
    end

    case (state_q)
      S_IDLE: begin
        if (START) begin
          for (int unsigned i = 0; i < NW; i++) rem_d[i] = LEN;
          term_d  = '0;
          hold_d  = '0;
          ptr_d   = '0;
          state_d = S_RUN;
          busy_d  = 1'b1;
        end
      end
      S_RUN: begin
        if ((&term_q) && hold_idle) begin
          state_d = S_FIN;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else if (gnt_vld) begin
          ptr_d       = gnt + W_LOG'(1);
          hold_d[gnt] = HW'(HOLD);
          dinen_d     = 1'b1;
          idx_d       = gnt;
          if (gnt_data) begin
            din_d      = SRC_DIN[int'(gnt)*BW +: BW];
            rem_d[gnt] = rem_q[gnt] - CNTW'(1);
          end else begin
            din_d       = '1;
            term_d[gnt] = 1'b1;
          end
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      term_q  <= '0;
      hold_q  <= '0;
      ptr_q   <= '0;
      din_q   <= '0;
      dinen_q <= 1'b0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      term_q  <= term_d;
      hold_q  <= hold_d;
      ptr_q   <= ptr_d;
      din_q   <= din_d;
      dinen_q <= dinen_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign TREE_DIN     = din_q;
  assign TREE_DINEN   = dinen_q;
  assign TREE_DIN_IDX = idx_q;
  assign BUSY         = busy_q;
  assign DONE         = done_q;

endmodule

// File: tb/tb_vtree_feed_scheduler.sv
// Bench for vtree_feed_scheduler: directed scenarios plus randomized traffic, checked
// every cycle against a behavioural model of the scheduling rules.
module tb_vtree_feed_scheduler;

  localparam int W_LOG = 3;
  localparam int P_LOG = 3;
  localparam int DATW  = 64;
  localparam int CNTW  = 32;
  localparam int HOLD  = 2;
  localparam int NW    = 8;
  localparam int BW    = 512;

  logic              CLK = 1'b0;
  logic              RST, START;
  logic [CNTW-1:0]   LEN;
  logic [BW*NW-1:0]  SRC_DIN;
  logic [NW-1:0]     SRC_VLD, SRC_DEQ, TREE_EMP;
  logic [BW-1:0]     TREE_DIN;
  logic              TREE_DINEN, BUSY, DONE;
  logic [W_LOG-1:0]  TREE_DIN_IDX;

  vtree_feed_scheduler #(.W_LOG(W_LOG), .P_LOG(P_LOG), .DATW(DATW), .CNTW(CNTW), .HOLD(HOLD)) dut (
    .CLK(CLK), .RST(RST), .START(START), .LEN(LEN), .SRC_DIN(SRC_DIN), .SRC_VLD(SRC_VLD),
    .SRC_DEQ(SRC_DEQ), .TREE_EMP(TREE_EMP), .TREE_DIN(TREE_DIN), .TREE_DINEN(TREE_DINEN),
    .TREE_DIN_IDX(TREE_DIN_IDX), .BUSY(BUSY), .DONE(DONE));

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: 0 idle, 1 run, 2 finishing
  int          m_state;
  longint      m_rem [NW];
  bit          m_term[NW];
  int          m_hold[NW];
  int          m_ptr;
  logic [BW-1:0] e_din;
  bit          e_dinen, e_busy, e_done, din_chk;
  int          e_idx;

  // Observation statistics
  int cyc = 0;
  int c_dinen, c_deq, c_done, done_cyc, way5_term_cyc, last_dinen_any, min_gap;
  int term_cnt[NW], pw_dinen[NW], pw_deq[NW], last_dinen[NW];
  int idx_log[$];

  task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_stats();
    c_dinen = 0; c_deq = 0; c_done = 0; done_cyc = -1; way5_term_cyc = -1;
    last_dinen_any = -1; idx_log.delete();
    for (int w = 0; w < NW; w++) begin
      term_cnt[w] = 0; pw_dinen[w] = 0; pw_deq[w] = 0; last_dinen[w] = -1000;
    end
  endtask

  function automatic int model_pick();
    int i;
    if (m_state != 1 || RST) return -1;
    for (int k = 0; k < NW; k++) begin
      i = (m_ptr + k) % NW;
      if (TREE_EMP[i] && m_hold[i] == 0 &&
          ((m_rem[i] != 0 && SRC_VLD[i]) || (m_rem[i] == 0 && !m_term[i])))
        return i;
    end
    return -1;
  endfunction

  task automatic cycle();
    int g;
    bit all_done;
    logic [NW-1:0] e_deq;
    for (int w = 0; w < BW*NW/32; w++) SRC_DIN[w*32 +: 32] = $urandom;
    g = model_pick();
    e_deq = (g >= 0 && m_rem[g] != 0) ? NW'(1 << g) : '0;
    #1;
    chk("src_deq", SRC_DEQ, e_deq);
    if (SRC_DEQ != 0) c_deq++;
    for (int w = 0; w < NW; w++) if (SRC_DEQ[w]) pw_deq[w]++;

    if (RST) begin
      m_state = 0; m_ptr = 0;
      for (int w = 0; w < NW; w++) begin m_rem[w] = 0; m_term[w] = 0; m_hold[w] = 0; end
      e_din = '0; e_dinen = 0; e_idx = 0; e_busy = 0; e_done = 0; din_chk = 1;
    end else begin
      din_chk = 0; e_dinen = 0; e_done = 0;
      case (m_state)
        0: if (START) begin
          for (int w = 0; w < NW; w++) begin m_rem[w] = LEN; m_term[w] = 0; m_hold[w] = 0; end
          m_ptr = 0; m_state = 1; e_busy = 1;
        end
        1: begin
          all_done = 1;
          for (int w = 0; w < NW; w++) if (!m_term[w] || m_hold[w] != 0) all_done = 0;
          for (int w = 0; w < NW; w++) if (m_hold[w] > 0) m_hold[w]--;
          if (all_done) begin
            m_state = 2; e_busy = 0; e_done = 1;
          end else if (g >= 0) begin
            m_ptr = (g + 1) % NW; m_hold[g] = HOLD; e_dinen = 1; e_idx = g;
            if (m_rem[g] != 0) begin e_din = SRC_DIN[g*BW +: BW]; m_rem[g]--; end
            else begin e_din = '1; m_term[g] = 1; end
          end
        end
        default: begin m_state = 0; e_busy = 0; end
      endcase
    end

    @(posedge CLK); #1;
    cyc++;
    chk("tree_dinen", TREE_DINEN, e_dinen);
    chk("busy", BUSY, e_busy);
    chk("done", DONE, e_done);
    if (e_dinen || din_chk) begin
      chk("tree_idx", TREE_DIN_IDX, e_idx);
      chk("tree_din", TREE_DIN, e_din);
    end

    if (TREE_DINEN) begin
      c_dinen++;
      pw_dinen[TREE_DIN_IDX]++;
      idx_log.push_back(int'(TREE_DIN_IDX));
      if (&TREE_DIN) begin
        term_cnt[TREE_DIN_IDX]++;
        if (TREE_DIN_IDX == 5) way5_term_cyc = cyc;
      end
      if (cyc - last_dinen[TREE_DIN_IDX] < min_gap) min_gap = cyc - last_dinen[TREE_DIN_IDX];
      last_dinen[TREE_DIN_IDX] = cyc;
      last_dinen_any = cyc;
    end
    if (DONE) begin c_done++; done_cyc = cyc; end
  endtask

  task automatic start(input int len);
    START = 1'b1; LEN = CNTW'(len);
    cycle();
    START = 1'b0;
  endtask

  task automatic run_until_done(input int budget, input string tag);
    int n = 0;
    int d0 = c_done;
    while (c_done == d0 && n < budget) begin cycle(); n++; end
    chk({tag, "_done_seen"}, c_done - d0, 1);
    cycle();
  endtask

  initial begin
    int mm, d0, n, len;
    min_gap = 1000;
    RST = 1'b1; START = 1'b0; LEN = '0; SRC_VLD = '0; TREE_EMP = '0; SRC_DIN = '0;
    reset_stats();
    cycle(); cycle();
    chk("reset_busy", BUSY, 0);
    chk("reset_din", TREE_DIN, 0);
    RST = 1'b0;
    cycle();

    // Basic: all ways ready, LEN=4
    reset_stats();
    SRC_VLD = '1; TREE_EMP = '1;
    start(4);
    run_until_done(300, "basic");
    chk("basic_dinen", c_dinen, 40);
    chk("basic_deq", c_deq, 32);
    chk("basic_done", c_done, 1);
    mm = 0;
    for (int k = 0; k < 40; k++) if (k >= idx_log.size() || idx_log[k] != k % NW) mm++;
    chk("basic_order", mm, 0);
    mm = 0;
    for (int w = 0; w < NW; w++) if (term_cnt[w] != 1) mm++;
    chk("basic_terms", mm, 0);
    chk("basic_done_gap", (done_cyc - last_dinen_any) >= HOLD, 1);

    // Hold masking: only way 3 eligible
    reset_stats();
    SRC_VLD = 8'h08; TREE_EMP = 8'h08;
    start(3);
    repeat (30) cycle();
    chk("hold_dinen", c_dinen, 4);
    chk("hold_deq", pw_deq[3], 3);
    chk("hold_term", term_cnt[3], 1);
    chk("hold_no_done", c_done, 0);
    chk("hold_order", (idx_log.size() == 4) && (idx_log[0] == 3) && (idx_log[3] == 3), 1);
    SRC_VLD = '1; TREE_EMP = '1;
    run_until_done(300, "hold");

    // Source stall on way 5
    reset_stats();
    SRC_VLD = 8'hDF; TREE_EMP = '1;
    start(2);
    repeat (30) cycle();
    chk("stall_w5_dinen", pw_dinen[5], 0);
    chk("stall_w5_deq", pw_deq[5], 0);
    chk("stall_no_done", c_done, 0);
    mm = 0;
    for (int w = 0; w < NW; w++) if (w != 5 && term_cnt[w] != 1) mm++;
    chk("stall_others_term", mm, 0);
    SRC_VLD = '1;
    run_until_done(300, "stall");
    chk("stall_w5_deq_after", pw_deq[5], 2);
    chk("stall_done_after_w5", (way5_term_cyc > 0) && (done_cyc > way5_term_cyc), 1);

    // LEN=0: terminators only
    reset_stats();
    SRC_VLD = 8'($urandom); TREE_EMP = '1;
    start(0);
    run_until_done(200, "len0");
    chk("len0_dinen", c_dinen, 8);
    chk("len0_deq", c_deq, 0);
    mm = 0;
    for (int k = 0; k < 8; k++) if (k >= idx_log.size() || idx_log[k] != k || term_cnt[k] != 1) mm++;
    chk("len0_order", mm, 0);

    // Randomized traffic with stray START pulses mid-run
    for (int r = 0; r < 3; r++) begin
      reset_stats();
      len = $urandom_range(1, 5);
      SRC_VLD = 8'($urandom); TREE_EMP = 8'($urandom);
      start(len);
      d0 = c_done; n = 0;
      while (c_done == d0 && n < 3000) begin
        SRC_VLD = 8'($urandom); TREE_EMP = 8'($urandom);
        START = ($urandom_range(0, 15) == 0); LEN = CNTW'($urandom_range(0, 9));
        cycle(); n++;
      end
      START = 1'b0;
      chk("rand_done_seen", c_done - d0, 1);
      cycle();
      mm = 0;
      for (int w = 0; w < NW; w++) if (term_cnt[w] != 1 || pw_deq[w] != len) mm++;
      chk("rand_per_way", mm, 0);
    end

    // Reset mid-run, then a fresh LEN=1 run
    reset_stats();
    SRC_VLD = '1; TREE_EMP = '1;
    start(3);
    n = 0;
    while (c_dinen < 10 && n < 100) begin cycle(); n++; end
    chk("rst_reach10", c_dinen >= 10, 1);
    RST = 1'b1;
    cycle();
    chk("rst_dinen", TREE_DINEN, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_idx", TREE_DIN_IDX, 0);
    RST = 1'b0;
    reset_stats();
    start(1);
    run_until_done(200, "rst_rerun");
    chk("rst_rerun_dinen", c_dinen, 16);
    chk("rst_rerun_deq", c_deq, 8);

    chk("min_gap", min_gap >= HOLD + 1, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
